// File: rtl/clk_div_sched.sv
// clk_div_sched: programmable divide-by-N controller.
// Generates a divided output Q and a period tick from clk. Ratio changes and
// start/stop requests are deferred to period boundaries, so no output period
// is ever truncated.
//
// Ports:
//   clk        system clock (rising edge)
//   rst        synchronous active-high reset
//   en         run request level
//   cfg_valid  ratio request valid
//   cfg_div    requested ratio N (>= 2 is valid)
//   cfg_ready  ratio request can be accepted (not PEND)
//   cfg_done   pulse in the first cycle a new ratio is in force
//   cfg_err    pulse the cycle after an invalid ratio is accepted
//   cur_div    ratio in force
//   running    state != IDLE
//   tick       last cycle of each output period
//   Q          divided output (registered)
module clk_div_sched #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             running,
  output logic             tick,
  output logic             Q
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt, cnt_nxt, pend_div;
  logic             accept, div_ok, upd, last;

  assign cfg_ready = (state != S_PEND);
  assign running   = (state != S_IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign div_ok    = (cfg_div >= CNT_W'(2));
  assign upd       = accept && div_ok;
  assign last      = (cnt == cur_div - 1'b1);
  assign cnt_nxt   = cnt + 1'b1;
  assign tick      = running && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur_div  <= CNT_W'(DEFAULT_DIV);
      pend_div <= '0;
      Q        <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= accept && !div_ok;
      case (state)
        S_RUN, S_PEND: begin
          if (last) begin
            cnt <= '0;
            // Wrap always uses the old ratio; a pending one takes over here.
            if (state == S_PEND) begin
              cur_div  <= pend_div;
              cfg_done <= 1'b1;
            end
            if (en) begin
              Q <= 1'b1;
              // Request landing on the boundary edge waits for the next one.
              if (upd) begin
                pend_div <= cfg_div;
                state    <= S_PEND;
              end else begin
                state    <= S_RUN;
              end
            end else begin
              Q     <= 1'b0;
              state <= S_IDLE;
              // Stopping: nothing left to defer to, apply immediately.
              if (upd) begin
                cur_div  <= cfg_div;
                cfg_done <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt_nxt;
            Q   <= (cnt_nxt < (cur_div >> 1));
            if (upd) begin
              pend_div <= cfg_div;
              state    <= S_PEND;
            end
          end
        end
        default: begin
          cnt <= '0;
          if (upd) begin
            cur_div  <= cfg_div;
            cfg_done <= 1'b1;
          end
          if (en) begin
            state <= S_RUN;
            Q     <= 1'b1;
          end else begin
            state <= S_IDLE;
            Q     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
module tb_clk_div_sched;
  localparam int CNT_W = 8;
  localparam int DEF   = 2;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic cfg_ready, cfg_done, cfg_err, running, tick, Q;
  logic [CNT_W-1:0] cur_div;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  clk_div_sched #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .cur_div(cur_div), .running(running), .tick(tick), .Q(Q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Abstract model: running flag, position in period, ratio, queue of waiting ratios.
  bit m_run = 0, m_done = 0, m_err = 0;
  int m_pos = 0, m_n = DEF;
  int m_pq[$];

  initial begin
    bit acc, good;
    forever begin
      @(posedge clk);
      acc = cfg_valid && (m_pq.size() == 0);
      good = acc && (int'(cfg_div) >= 2);
      m_done = 0;
      m_err  = 0;
      if (rst) begin
        m_run = 0; m_pos = 0; m_n = DEF; m_pq.delete();
      end else begin
        if (acc && !good) m_err = 1;
        if (!m_run) begin
          if (good) begin m_n = int'(cfg_div); m_done = 1; end
          m_pos = 0;
          m_run = en;
        end else if (m_pos == m_n - 1) begin
          m_pos = 0;
          if (m_pq.size() > 0) begin m_n = m_pq.pop_front(); m_done = 1; end
          if (good) begin
            if (en) m_pq.push_back(int'(cfg_div));
            else begin m_n = int'(cfg_div); m_done = 1; end
          end
          m_run = en;
        end else begin
          m_pos++;
          if (good) m_pq.push_back(int'(cfg_div));
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("Q",         Q,         (m_run && m_pos < m_n / 2) ? 1 : 0);
        check("tick",      tick,      (m_run && m_pos == m_n - 1) ? 1 : 0);
        check("running",   running,   m_run);
        check("cur_div",   cur_div,   m_n);
        check("cfg_ready", cfg_ready, (m_pq.size() == 0) ? 1 : 0);
        check("cfg_done",  cfg_done,  m_done);
        check("cfg_err",   cfg_err,   m_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; cfg_valid = 0; cfg_div = '0;
    step();
    rst = 0;
  endtask

  task automatic set_div_idle(input int n);
    cfg_valid = 1; cfg_div = CNT_W'(n);
    step();
    cfg_valid = 0;
  endtask

  initial begin
    logic [4:0] qp5;
    logic [5:0] qp6;

    // Reset state
    step(); step();
    chk_en = 1;
    check("rst_Q", Q, 0);
    check("rst_cur_div", cur_div, DEF);
    check("rst_ready", cfg_ready, 1);
    check("rst_running", running, 0);
    check("rst_tick", tick, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    rst = 0;

    // Default ratio 2
    en = 1;
    step(); check("d2_Q0", Q, 1); check("d2_run", running, 1); check("d2_tick0", tick, 0);
    step(); check("d2_Q1", Q, 0); check("d2_tick1", tick, 1);
    step(); check("d2_Q2", Q, 1);
    step(); check("d2_Q3", Q, 0);

    // Ratio 5 set in IDLE
    do_reset();
    set_div_idle(5);
    check("n5_cur", cur_div, 5); check("n5_done", cfg_done, 1);
    en = 1;
    step();
    qp5 = 5'b11000;
    for (int i = 0; i < 10; i++) begin
      check("n5_Q", Q, qp5[4 - (i % 5)]);
      check("n5_tick", tick, (i % 5 == 4) ? 1 : 0);
      step();
    end

    // Running N=4, request 6 at cnt=1
    do_reset();
    set_div_idle(4);
    en = 1;
    step(); step();
    cfg_valid = 1; cfg_div = 8'd6;
    step();
    cfg_valid = 0;
    check("n46_ready", cfg_ready, 0); check("n46_Q2", Q, 0);
    step();
    check("n46_tick", tick, 1); check("n46_ready3", cfg_ready, 0); check("n46_cur4", cur_div, 4);
    step();
    check("n46_cur6", cur_div, 6); check("n46_done", cfg_done, 1);
    qp6 = 6'b111000;
    for (int i = 0; i < 12; i++) begin
      check("n6_Q", Q, qp6[5 - (i % 6)]);
      step();
    end

    // Invalid ratios while running N=3
    do_reset();
    set_div_idle(3);
    en = 1;
    step(); step();
    cfg_valid = 1; cfg_div = 8'd0;
    step();
    cfg_valid = 0;
    check("err0", cfg_err, 1); check("err0_cur", cur_div, 3); check("err0_ready", cfg_ready, 1);
    step();
    check("err0_clr", cfg_err, 0);
    cfg_valid = 1; cfg_div = 8'd1;
    step();
    cfg_valid = 0;
    check("err1", cfg_err, 1);
    repeat (6) step();
    check("err_cur", cur_div, 3);

    // Stop at N=8 with en dropped at cnt=2
    do_reset();
    set_div_idle(8);
    en = 1;
    step(); step(); step();
    en = 0;
    repeat (5) step();
    check("stop_tick", tick, 1); check("stop_run7", running, 1); check("stop_Q7", Q, 0);
    step();
    check("stop_run", running, 0); check("stop_Q", Q, 0);
    step();
    check("stop_idle", running, 0);
    // en glitch low mid-period must not stop
    en = 1;
    step(); step(); step();
    en = 0;
    step();
    en = 1;
    repeat (5) step();
    check("glitch_run", running, 1); check("glitch_Q", Q, 1);

    // Reset while PEND
    do_reset();
    set_div_idle(4);
    en = 1;
    step(); step();
    cfg_valid = 1; cfg_div = 8'd7;
    step();
    cfg_valid = 0;
    check("pend_ready", cfg_ready, 0);
    rst = 1;
    step();
    rst = 0;
    check("prst_Q", Q, 0); check("prst_cur", cur_div, DEF);
    check("prst_ready", cfg_ready, 1); check("prst_run", running, 0);
    repeat (12) step();
    check("prst_never7", cur_div, DEF);

    // Same-ratio request accepted on the boundary edge
    do_reset();
    set_div_idle(3);
    en = 1;
    step(); step(); step();
    cfg_valid = 1; cfg_div = 8'd3;
    step();
    cfg_valid = 0;
    check("bnd_ready", cfg_ready, 0); check("bnd_done0", cfg_done, 0); check("bnd_Q", Q, 1);
    step(); step(); step();
    check("bnd_done", cfg_done, 1); check("bnd_cur", cur_div, 3);
    en = 0;
    repeat (6) step();
    check("bnd_idle", running, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
